// File: rtl/mips25_alu_pkg.sv
// Shared ALU definitions: logic-unit op encoding and parameter limits.
package mips25_alu_pkg;

  localparam int LOGIC_W_MAX      = 64;
  localparam int LOGIC_STAGES_MAX = 4;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } logic_op_e;

endpackage

// File: rtl/logic_unit_stage.sv
// One pipeline slot: valid + data register, loads on en_i, async clear to RST_VAL.
// Latency 1 cycle; holds contents whenever en_i is low.
module logic_unit_stage
  import mips25_alu_pkg::*;
#(
  parameter int            DW      = 16,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);

  logic          vld_q;
  logic [DW-1:0] dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= RST_VAL;
    end else if (en_i) begin
      vld_q <= vld_i;
      dat_q <= dat_i;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit, STAGES cycles latency; a stalled output freezes the whole pipe.
// LOGIC_UNIT_FLAGS_EN adds zero/parity flags carried alongside the result.
module logic_unit_pipe
  import mips25_alu_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clkpos,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         busy
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic         zero,
  output logic         parity
`endif
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int FW = 2;
  // Reset image {zero, parity, result} so flags agree with out == 0.
  localparam logic [W+FW-1:0] RST_VAL = {1'b1, 1'b0, {W{1'b0}}};
`else
  localparam int FW = 0;
  localparam logic [W+FW-1:0] RST_VAL = '0;
`endif
  localparam int DW = W + FW;

  logic            adv;
  logic [W-1:0]    res_d;
  logic [STAGES:0] vld_c;
  logic [DW-1:0]   dat_c [STAGES+1];

  always_comb begin
    res_d = '0;
    case (logic_op_e'(op))
      OP_AND:    res_d = a & b;
      OP_OR:     res_d = a | b;
      OP_XOR:    res_d = a ^ b;
      OP_NAND:   res_d = ~(a & b);
      OP_NOR:    res_d = ~(a | b);
      OP_XNOR:   res_d = ~(a ^ b);
      OP_PASS_A: res_d = a;
      OP_NOT_A:  res_d = ~a;
      default:   res_d = '0;
    endcase
  end

  // Single global enable: any stall at the output holds every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign vld_c[0] = in_valid;

`ifdef LOGIC_UNIT_FLAGS_EN
  assign dat_c[0] = {~|res_d, ^res_d, res_d};
`else
  assign dat_c[0] = res_d;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic_unit_stage #(
      .DW      (DW),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i  (clkpos),
      .rst_ni (rstn),
      .en_i   (adv),
      .vld_i  (vld_c[s]),
      .dat_i  (dat_c[s]),
      .vld_o  (vld_c[s+1]),
      .dat_o  (dat_c[s+1])
    );
  end

  assign out_valid = vld_c[STAGES];
  assign out       = dat_c[STAGES][W-1:0];
  assign busy      = |vld_c[STAGES:1];

`ifdef LOGIC_UNIT_FLAGS_EN
  assign zero   = dat_c[STAGES][W+1];
  assign parity = dat_c[STAGES][W];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three instances (16/2, 1/1, 64/4) against a queue-based reference.
module tb_logic_unit_pipe;

  int errors = 0;
  int checks = 0;

  logic clkpos = 1'b0;
  logic rstn   = 1'b0;
  always #5 clkpos = ~clkpos;

  logic        iv0 = 1'b0, ordy0 = 1'b1, ir0, ov0, busy0;
  logic [2:0]  op0 = 3'd0;
  logic [15:0] a0 = '0, b0 = '0, out0;
  logic        iv1 = 1'b0, ordy1 = 1'b1, ir1, ov1, busy1;
  logic [2:0]  op1 = 3'd0;
  logic [0:0]  a1 = '0, b1 = '0, out1;
  logic        iv2 = 1'b0, ordy2 = 1'b1, ir2, ov2, busy2;
  logic [2:0]  op2 = 3'd0;
  logic [63:0] a2 = '0, b2 = '0, out2;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero0, par0, zero1, par1, zero2, par2;
`endif

  logic_unit_pipe #(.W(16), .STAGES(2)) u0 (
    .clkpos(clkpos), .rstn(rstn), .in_valid(iv0), .in_ready(ir0), .op(op0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(ordy0), .out(out0), .busy(busy0)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .zero(zero0), .parity(par0)
`endif
  );
  logic_unit_pipe #(.W(1), .STAGES(1)) u1 (
    .clkpos(clkpos), .rstn(rstn), .in_valid(iv1), .in_ready(ir1), .op(op1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(ordy1), .out(out1), .busy(busy1)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .zero(zero1), .parity(par1)
`endif
  );
  logic_unit_pipe #(.W(64), .STAGES(4)) u2 (
    .clkpos(clkpos), .rstn(rstn), .in_valid(iv2), .in_ready(ir2), .op(op2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(ordy2), .out(out2), .busy(busy2)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .zero(zero2), .parity(par2)
`endif
  );

  // Reference: the eight bitwise ops, truncated to the operand width.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x,
                                         input logic [63:0] y, input int w);
    logic [63:0] r;
    case (o)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x;
      default: r = ~x;
    endcase
    if (w < 64) r = r & ((64'd1 << w) - 64'd1);
    return r;
  endfunction

  logic        acc0, emit0, ovs0, irs0;
  logic [15:0] obs0;
  logic [15:0] ops_exp [8];

  task automatic step0(input logic iv, input logic [2:0] o, input logic [15:0] av,
                       input logic [15:0] bv, input logic ordy);
    @(negedge clkpos);
    iv0 = iv; op0 = o; a0 = av; b0 = bv; ordy0 = ordy;
    #1;
    irs0 = ir0; ovs0 = ov0; obs0 = out0;
    acc0 = iv && ir0;
    emit0 = ov0 && ordy;
  endtask

  task automatic test_reset();
    int lat;
    rstn = 1'b0;
    iv0 = 1'b1; op0 = 3'd0; a0 = 16'hF0F0; b0 = 16'hFF00; ordy0 = 1'b1;
    iv1 = 1'b1; iv2 = 1'b1; a2 = 64'hFFFF_FFFF_FFFF_FFFF; b2 = a2;
    repeat (3) @(negedge clkpos);
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir0); end
    checks++; if (out0 !== 16'h0) begin errors++; $display("FAIL reset_out: got %h want 0000", out0); end
    checks++; if (ov2 !== 1'b0 || busy2 !== 1'b0 || out2 !== 64'h0) begin
      errors++; $display("FAIL reset_w64: got v=%b busy=%b out=%h want 0/0/0", ov2, busy2, out2); end
    checks++; if (ov1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_w1: got v=%b busy=%b want 0/0", ov1, busy1); end
`ifdef LOGIC_UNIT_FLAGS_EN
    checks++; if (zero0 !== 1'b1 || par0 !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got zero=%b parity=%b want 1/0", zero0, par0); end
`endif
    iv1 = 1'b0; iv2 = 1'b0;
    @(negedge clkpos);
    rstn = 1'b1;
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", ir0); end
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step0(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
      lat++;
      if (ovs0) break;
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL first_latency: got %0d want 2", lat); end
    checks++; if (obs0 !== 16'hF000) begin errors++; $display("FAIL first_and: got %h want f000", obs0); end
  endtask

  task automatic test_all_ops();
    int k, first, last;
    ops_exp = '{16'h0034, 16'h12FF, 16'h12CB, 16'hFFCB, 16'hED00, 16'hED34, 16'h1234, 16'hEDCB};
    k = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      step0(i < 8, 3'(i), 16'h1234, 16'h00FF, 1'b1);
      if (i < 8) begin
        checks++; if (acc0 !== 1'b1) begin errors++; $display("FAIL ops_accept[%0d]: got %b want 1", i, acc0); end
      end
      if (emit0) begin
        if (k < 8) begin
          checks++; if (obs0 !== ops_exp[k]) begin
            errors++; $display("FAIL ops_result[%0d]: got %h want %h", k, obs0, ops_exp[k]); end
        end
        if (first < 0) first = i;
        last = i;
        k++;
      end
    end
    checks++; if (k != 8) begin errors++; $display("FAIL ops_count: got %0d want 8", k); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL ops_rate: got span %0d want 7", last - first); end
  endtask

  task automatic test_stall();
    logic [2:0]  bo [4];
    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic [15:0] q[$];
    logic [15:0] hold, e;
    logic [63:0] r;
    logic        ordy;
    int sent, got, stall_left, idx;
    for (int i = 0; i < 4; i++) begin
      bo[i] = 3'($urandom); ba[i] = 16'($urandom); bb[i] = 16'($urandom);
    end
    sent = 0; got = 0; stall_left = 3; hold = '0;
    for (int t = 0; t < 30; t++) begin
      ordy = !(got > 0 && stall_left > 0);
      idx = (sent < 4) ? sent : 3;
      step0(sent < 4, bo[idx], ba[idx], bb[idx], ordy);
      if (!ordy) begin
        checks++; if (ovs0 !== 1'b1 || irs0 !== 1'b0 || acc0 !== 1'b0) begin
          errors++; $display("FAIL stall_freeze: got v=%b rdy=%b acc=%b want 1/0/0", ovs0, irs0, acc0); end
        if (stall_left == 3) hold = obs0;
        else begin
          checks++; if (obs0 !== hold) begin errors++; $display("FAIL stall_hold: got %h want %h", obs0, hold); end
        end
        stall_left--;
      end
      if (acc0) begin
        r = ref_op(bo[idx], {48'h0, ba[idx]}, {48'h0, bb[idx]}, 16);
        q.push_back(r[15:0]);
        sent++;
      end
      if (emit0) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stall_extra: got %h want none", obs0); end
        else begin
          e = q.pop_front();
          if (obs0 !== e) begin errors++; $display("FAIL stall_order[%0d]: got %h want %h", got, obs0, e); end
        end
        got++;
      end
    end
    checks++; if (got != 4 || sent != 4) begin errors++; $display("FAIL stall_count: got %0d/%0d want 4/4", sent, got); end
  endtask

  task automatic test_midreset();
    int stale;
    step0(1'b1, 3'd1, 16'($urandom), 16'($urandom), 1'b0);
    step0(1'b1, 3'd2, 16'($urandom), 16'($urandom), 1'b0);
    @(negedge clkpos);
    iv0 = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL midrst_loaded: got v=%b busy=%b want 1/1", ov0, busy0); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got v=%b busy=%b want 0/0", ov0, busy0); end
    checks++; if (ir0 !== 1'b1 || out0 !== 16'h0) begin
      errors++; $display("FAIL midrst_state: got rdy=%b out=%h want 1/0000", ir0, out0); end
    @(negedge clkpos);
    rstn = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step0(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
      if (ovs0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale: got %0d want 0", stale); end
  endtask

  task automatic test_latency();
    logic [63:0] e0, e1, e2, g0, g1, g2;
    int l0, l1, l2;
    @(negedge clkpos);
    iv0 = 1'b1; op0 = 3'($urandom); a0 = 16'($urandom); b0 = 16'($urandom); ordy0 = 1'b1;
    iv1 = 1'b1; op1 = 3'($urandom); a1 = 1'($urandom);  b1 = 1'($urandom);  ordy1 = 1'b1;
    iv2 = 1'b1; op2 = 3'($urandom); a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; ordy2 = 1'b1;
    e0 = ref_op(op0, {48'h0, a0}, {48'h0, b0}, 16);
    e1 = ref_op(op1, {63'h0, a1}, {63'h0, b1}, 1);
    e2 = ref_op(op2, a2, b2, 64);
    #1;
    checks++; if (ir0 !== 1'b1 || ir1 !== 1'b1 || ir2 !== 1'b1) begin
      errors++; $display("FAIL lat_accept: got %b%b%b want 111", ir0, ir1, ir2); end
    l0 = -1; l1 = -1; l2 = -1; g0 = '0; g1 = '0; g2 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clkpos);
      iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
      #1;
      if (ov0 && l0 < 0) begin l0 = c; g0 = {48'h0, out0}; end
      if (ov1 && l1 < 0) begin l1 = c; g1 = {63'h0, out1}; end
      if (ov2 && l2 < 0) begin l2 = c; g2 = out2; end
    end
    checks++; if (l0 != 2) begin errors++; $display("FAIL lat_w16s2: got %0d want 2", l0); end
    checks++; if (l1 != 1) begin errors++; $display("FAIL lat_w1s1: got %0d want 1", l1); end
    checks++; if (l2 != 4) begin errors++; $display("FAIL lat_w64s4: got %0d want 4", l2); end
    checks++; if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
      errors++; $display("FAIL lat_data: got %h/%h/%h want %h/%h/%h", g0, g1, g2, e0, e1, e2); end
  endtask

  task automatic test_sweep();
    logic [63:0] q0[$], q1[$], q2[$];
    logic [63:0] e;
    for (int t = 0; t < 412; t++) begin
      @(negedge clkpos);
      iv0 = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      iv1 = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      iv2 = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ordy0 = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      ordy1 = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      ordy2 = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      op0 = 3'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
      op1 = 3'($urandom); a1 = 1'($urandom);  b1 = 1'($urandom);
      op2 = 3'($urandom); a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      #1;
      checks++; if (ir0 !== (!ov0 || ordy0) || ir1 !== (!ov1 || ordy1) || ir2 !== (!ov2 || ordy2)) begin
        errors++; $display("FAIL sweep_ready[%0d]: got %b%b%b", t, ir0, ir1, ir2); end
      if (ov0 && ordy0) begin
        checks++;
        if (q0.size() == 0) begin errors++; $display("FAIL sweep_extra_w16: got %h want none", out0); end
        else begin
          e = q0.pop_front();
          if ({48'h0, out0} !== e) begin errors++; $display("FAIL sweep_w16[%0d]: got %h want %h", t, out0, e); end
`ifdef LOGIC_UNIT_FLAGS_EN
          if (zero0 !== (e == 64'h0) || par0 !== ^e) begin
            errors++; $display("FAIL sweep_flags_w16[%0d]: got %b%b", t, zero0, par0); end
`endif
        end
      end
      if (ov1 && ordy1) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL sweep_extra_w1: got %h want none", out1); end
        else begin
          e = q1.pop_front();
          if ({63'h0, out1} !== e) begin errors++; $display("FAIL sweep_w1[%0d]: got %h want %h", t, out1, e); end
`ifdef LOGIC_UNIT_FLAGS_EN
          if (zero1 !== (e == 64'h0) || par1 !== ^e) begin
            errors++; $display("FAIL sweep_flags_w1[%0d]: got %b%b", t, zero1, par1); end
`endif
        end
      end
      if (ov2 && ordy2) begin
        checks++;
        if (q2.size() == 0) begin errors++; $display("FAIL sweep_extra_w64: got %h want none", out2); end
        else begin
          e = q2.pop_front();
          if (out2 !== e) begin errors++; $display("FAIL sweep_w64[%0d]: got %h want %h", t, out2, e); end
`ifdef LOGIC_UNIT_FLAGS_EN
          if (zero2 !== (e == 64'h0) || par2 !== ^e) begin
            errors++; $display("FAIL sweep_flags_w64[%0d]: got %b%b", t, zero2, par2); end
`endif
        end
      end
      if (iv0 && ir0) q0.push_back(ref_op(op0, {48'h0, a0}, {48'h0, b0}, 16));
      if (iv1 && ir1) q1.push_back(ref_op(op1, {63'h0, a1}, {63'h0, b1}, 1));
      if (iv2 && ir2) q2.push_back(ref_op(op2, a2, b2, 64));
    end
    checks++; if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      errors++; $display("FAIL sweep_drain: got %0d/%0d/%0d left want 0", q0.size(), q1.size(), q2.size()); end
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL sweep_idle_busy: got %b%b%b want 000", busy0, busy1, busy2); end
  endtask

`ifdef LOGIC_UNIT_FLAGS_EN
  task automatic test_flags();
    logic [15:0] eo [2];
    logic        ez [2];
    logic        ep [2];
    int k;
    eo = '{16'h0000, 16'h0001}; ez = '{1'b1, 1'b0}; ep = '{1'b0, 1'b1};
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      step0(1'b1, 3'd2, 16'hA5A5, 16'hA5A5, 1'b1);
      else if (i == 1) step0(1'b1, 3'd1, 16'h0001, 16'h0000, 1'b1);
      else             step0(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
      if (emit0 && k < 2) begin
        checks++; if (obs0 !== eo[k] || zero0 !== ez[k] || par0 !== ep[k]) begin
          errors++; $display("FAIL flags[%0d]: got out=%h z=%b p=%b want %h/%b/%b",
                             k, obs0, zero0, par0, eo[k], ez[k], ep[k]); end
        k++;
      end
    end
    checks++; if (k != 2) begin errors++; $display("FAIL flags_count: got %0d want 2", k); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ops();
    test_stall();
    test_midreset();
    test_latency();
    test_sweep();
`ifdef LOGIC_UNIT_FLAGS_EN
    test_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
